// File: rtl/spi_master_ss.sv
// SPI master with slave-select, configurable CPOL/CPHA and timing.
// Ports: clk/rst, arm/ready_to_arm/finished, to_slave/from_slave, mosi/miso/sck_wire/ss_L.
module spi_master_ss #(
  parameter int WID             = 24,
  parameter int WID_LEN         = 5,
  parameter int CYCLE_HALF_WAIT = 1,
  parameter int SS_WAIT         = 1,
  parameter int TIMER_LEN       = 8,
  parameter int POLARITY        = 0,
  parameter int PHASE           = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           arm,
  output logic           ready_to_arm,
  output logic           finished,
  input  logic [WID-1:0] to_slave,
  output logic [WID-1:0] from_slave,
  output logic           mosi,
  input  logic           miso,
  output logic           sck_wire,
  output logic           ss_L
);

  localparam logic POL = (POLARITY != 0);
  localparam logic CPHA = (PHASE != 0);
  localparam logic [TIMER_LEN-1:0] SS_LAST =
    TIMER_LEN'(SS_WAIT - 1);
  localparam logic [TIMER_LEN-1:0] HALF_LAST =
    TIMER_LEN'(CYCLE_HALF_WAIT - 1);
  localparam logic [WID_LEN-1:0] LAST_BIT =
    WID_LEN'(WID - 1);
  localparam logic [WID_LEN-1:0] ALL_BITS =
    WID_LEN'(WID);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    CLOCKING,
    DONE
  } state_t;

  state_t state, state_n;

  logic [TIMER_LEN-1:0] timer, timer_n;
  logic [WID_LEN-1:0]   bit_cnt, bit_cnt_n;
  logic [WID-1:0]       shift, shift_n;
  logic [WID-1:0]       rx, rx_n;
  logic                 sck_n;
  logic                 ss_n;
  logic                 mosi_n;
  logic                 do_edge;
  logic                 leading;

  assign ready_to_arm = (state == IDLE);
  assign finished     = (state == DONE);
  assign from_slave   = rx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      rx       <= '0;
      sck_wire <= POL;
      ss_L     <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      rx       <= rx_n;
      sck_wire <= sck_n;
      ss_L     <= ss_n;
      mosi     <= mosi_n;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    rx_n      = rx;
    sck_n     = sck_wire;
    ss_n      = ss_L;
    mosi_n    = mosi;
    do_edge   = 1'b0;
    leading   = 1'b0;

    unique case (state)
      IDLE: begin
        if (arm) begin
          state_n   = SETUP;
          ss_n      = 1'b0;
          shift_n   = to_slave;
          rx_n      = '0;
          timer_n   = '0;
          bit_cnt_n = '0;
          // CPHA=0 slaves sample on the first edge, so the MSB
          // must already be on the wire when ss_L drops.
          mosi_n    = CPHA ? 1'b0 : to_slave[WID-1];
        end
      end
      SETUP: begin
        if (timer == SS_LAST) begin
          timer_n = '0;
          state_n = CLOCKING;
          do_edge = 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      CLOCKING: begin
        if (timer == HALF_LAST) begin
          timer_n = '0;
          if (bit_cnt == ALL_BITS) begin
            state_n = DONE;
            ss_n    = 1'b1;
            mosi_n  = 1'b0;
          end else begin
            do_edge = 1'b1;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DONE: begin
        if (!arm) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (do_edge) begin
      sck_n   = ~sck_wire;
      leading = (sck_wire == POL);
      if (leading) begin
        if (CPHA) begin
          mosi_n  = shift[WID-1];
          shift_n = shift << 1;
        end else begin
          rx_n = {rx[WID-2:0], miso};
        end
      end else begin
        bit_cnt_n = bit_cnt + 1'b1;
        if (CPHA) begin
          rx_n = {rx[WID-2:0], miso};
        end else if (bit_cnt != LAST_BIT) begin
          shift_n = shift << 1;
          mosi_n  = shift[WID-2];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ss.sv
// Directed bench for spi_master_ss: three configurations,
// loopback and slave-model transfers, reset abort, arm handling.
module tb_spi_master_ss;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // instance A: WID=8, CPOL=0, CPHA=0, loopback
  logic       arm_a = 1'b0;
  logic       rdy_a, fin_a, mosi_a, sck_a, ss_a;
  logic [7:0] tx_a = '0;
  logic [7:0] rx_a;

  // instance B: WID=8, CPOL=1, CPHA=1, slave model
  logic       arm_b = 1'b0;
  logic       rdy_b, fin_b, mosi_b, sck_b, ss_b, miso_b;
  logic [7:0] tx_b = '0;
  logic [7:0] rx_b;
  logic [7:0] slv_b = 8'h3C;

  // instance C: WID=24, half=1, ss_wait=3, loopback
  logic        arm_c = 1'b0;
  logic        rdy_c, fin_c, mosi_c, sck_c, ss_c;
  logic [23:0] tx_c = '0;
  logic [23:0] rx_c;

  assign miso_b = slv_b[7];

  spi_master_ss #(
    .WID(8), .WID_LEN(4), .CYCLE_HALF_WAIT(2),
    .SS_WAIT(1), .POLARITY(0), .PHASE(0)
  ) u_a (
    .clk(clk), .rst(rst), .arm(arm_a),
    .ready_to_arm(rdy_a), .finished(fin_a),
    .to_slave(tx_a), .from_slave(rx_a),
    .mosi(mosi_a), .miso(mosi_a),
    .sck_wire(sck_a), .ss_L(ss_a)
  );

  spi_master_ss #(
    .WID(8), .WID_LEN(4), .CYCLE_HALF_WAIT(2),
    .SS_WAIT(1), .POLARITY(1), .PHASE(1)
  ) u_b (
    .clk(clk), .rst(rst), .arm(arm_b),
    .ready_to_arm(rdy_b), .finished(fin_b),
    .to_slave(tx_b), .from_slave(rx_b),
    .mosi(mosi_b), .miso(miso_b),
    .sck_wire(sck_b), .ss_L(ss_b)
  );

  spi_master_ss #(
    .WID(24), .WID_LEN(5), .CYCLE_HALF_WAIT(1),
    .SS_WAIT(3), .POLARITY(0), .PHASE(0)
  ) u_c (
    .clk(clk), .rst(rst), .arm(arm_c),
    .ready_to_arm(rdy_c), .finished(fin_c),
    .to_slave(tx_c), .from_slave(rx_c),
    .mosi(mosi_c), .miso(mosi_c),
    .sck_wire(sck_c), .ss_L(ss_c)
  );

  // line monitors, sampled on the falling clock edge
  int          tog_a = 0, low_a = 0, fall_a = 0;
  logic        psck_a = 1'b0, pss_a = 1'b1, fm_a = 1'b0;
  logic [31:0] mw_a = '0;
  int          tog_b = 0, low_b = 0;
  logic        psck_b = 1'b1;
  int          tog_c = 0, low_c = 0;
  logic        psck_c = 1'b0;
  logic [31:0] mw_c = '0;

  always @(negedge clk) begin
    if (sck_a != psck_a) tog_a++;
    if (!psck_a && sck_a && !ss_a) mw_a = {mw_a[30:0], mosi_a};
    if (!ss_a) low_a++;
    if (pss_a && !ss_a) begin
      fall_a++;
      fm_a = mosi_a;
    end
    psck_a = sck_a;
    pss_a  = ss_a;
  end

  always @(negedge clk) begin
    if (sck_b != psck_b) tog_b++;
    if (!ss_b) low_b++;
    if (ss_b) slv_b = 8'h3C;
    else if (!psck_b && sck_b) slv_b = slv_b << 1;
    psck_b = sck_b;
  end

  always @(negedge clk) begin
    if (sck_c != psck_c) tog_c++;
    if (!psck_c && sck_c && !ss_c) mw_c = {mw_c[30:0], mosi_c};
    if (!ss_c) low_c++;
    psck_c = sck_c;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fin(input string tag, input int which);
    int   n;
    logic f;
    n = 0;
    f = 1'b0;
    while (!f && n < 2000) begin
      tick();
      n++;
      f = (which == 0) ? fin_a : (which == 1) ? fin_b : fin_c;
    end
    check(tag, {31'd0, f}, 32'd1);
  endtask

  task automatic wait_tog(input string tag, input int base,
                          input int cnt);
    int n;
    n = 0;
    while ((tog_a - base) < cnt && n < 2000) begin
      tick();
      n++;
    end
    check(tag, tog_a - base, cnt);
  endtask

  int b_tog, b_low, b_fall;

  initial begin
    tick();
    check("rst_ss", ss_a, 1);
    check("rst_sck_a", sck_a, 0);
    check("rst_sck_b", sck_b, 1);
    check("rst_mosi", mosi_a, 0);
    check("rst_fin", fin_a, 0);
    check("rst_rx", rx_a, 0);
    check("rst_rdy", rdy_a, 1);
    rst = 1'b0;
    repeat (2) tick();

    // A: 0xA5 loopback, CPHA=0
    tx_a = 8'hA5;
    b_tog = tog_a; b_low = low_a;
    arm_a = 1'b1;
    tick();
    arm_a = 1'b0;
    check("a_rdy_busy", rdy_a, 0);
    check("a_first_mosi", fm_a, 1);
    wait_fin("a_done", 0);
    check("a_mosi_bits", mw_a[7:0], 8'hA5);
    check("a_toggles", tog_a - b_tog, 16);
    check("a_ss_low", low_a - b_low, 33);
    check("a_rx", rx_a, 8'hA5);
    check("a_sck_idle", sck_a, 0);
    check("a_ss_high", ss_a, 1);
    repeat (2) tick();

    // B: CPOL=1 CPHA=1, slave returns 0x3C
    tx_b = 8'h96;
    b_tog = tog_b; b_low = low_b;
    arm_b = 1'b1;
    tick();
    arm_b = 1'b0;
    wait_fin("b_done", 1);
    check("b_rx", rx_b, 8'h3C);
    check("b_toggles", tog_b - b_tog, 16);
    check("b_ss_low", low_b - b_low, 33);
    check("b_sck_idle", sck_b, 1);
    repeat (2) tick();

    // A: reset after the 5th toggle aborts
    tx_a = 8'hC3;
    b_tog = tog_a;
    arm_a = 1'b1;
    tick();
    arm_a = 1'b0;
    wait_tog("rst_tog5", b_tog, 5);
    rst = 1'b1;
    #1;
    check("abort_ss", ss_a, 1);
    check("abort_sck", sck_a, 0);
    check("abort_fin", fin_a, 0);
    check("abort_rx", rx_a, 0);
    check("abort_rdy", rdy_a, 1);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    tx_a = 8'h0F;
    b_low = low_a;
    arm_a = 1'b1;
    tick();
    arm_a = 1'b0;
    wait_fin("post_rst_done", 0);
    check("post_rst_rx", rx_a, 8'h0F);
    check("post_rst_low", low_a - b_low, 33);
    repeat (2) tick();

    // A: arm held 100 cycles -> one transfer
    tx_a = 8'h5A;
    b_fall = fall_a;
    arm_a = 1'b1;
    repeat (100) tick();
    check("hold_fin", fin_a, 1);
    check("hold_one", fall_a - b_fall, 1);
    check("hold_rx", rx_a, 8'h5A);
    check("hold_rdy_lo", rdy_a, 0);
    arm_a = 1'b0;
    tick();
    check("hold_rdy", rdy_a, 1);
    check("hold_fin_clr", fin_a, 0);
    repeat (2) tick();

    // A: to_slave and arm disturbed mid-transfer
    tx_a = 8'hA5;
    b_fall = fall_a; b_low = low_a;
    arm_a = 1'b1;
    tick();
    arm_a = 1'b0;
    wait_tog("mid_tog4", tog_a, 4);
    tx_a = 8'hFF;
    arm_a = 1'b1;
    repeat (3) tick();
    arm_a = 1'b0;
    repeat (2) tick();
    arm_a = 1'b1;
    tick();
    arm_a = 1'b0;
    wait_fin("mid_done", 0);
    check("mid_mosi", mw_a[7:0], 8'hA5);
    check("mid_rx", rx_a, 8'hA5);
    check("mid_low", low_a - b_low, 33);
    repeat (3) tick();
    check("mid_one", fall_a - b_fall, 1);
    check("mid_idle_ss", ss_a, 1);

    // C: WID=24, 0x800001 loopback
    tx_c = 24'h800001;
    b_tog = tog_c; b_low = low_c;
    arm_c = 1'b1;
    tick();
    arm_c = 1'b0;
    wait_fin("c_done", 2);
    check("c_rx", rx_c, 24'h800001);
    check("c_mosi", mw_c[23:0], 24'h800001);
    check("c_toggles", tog_c - b_tog, 48);
    check("c_ss_low", low_c - b_low, 51);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
